jk_bank_sequencer: RTL and testbench
====================================

JK_BANK_SEQUENCER -- requirements
Module: jk_bank_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of JK cells in the bank (legal range 2..32).
REQ-002 SHALL have parameter STEP_W, default 8, width of the count-step field.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-007 SHALL have port cmd_op  input  3  opcode, encoded as in REQ-013.
REQ-008 SHALL have port cmd_data  input  WIDTH  bit mask or load value.
REQ-009 SHALL have port cmd_steps  input  STEP_W  number of count cycles.
REQ-010 SHALL have port q  output  WIDTH  bank state; bit i is the Q of cell i.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking command completion.

Function
REQ-013 SHALL decode cmd_op as follows; J/K are applied per bit.
- 0 NOP: J=0, K=0.
- 1 SET: J=data, K=0.
- 2 CLR: J=0, K=data.
- 3 TOG: J=data, K=data.
- 4 LOAD: J=data, K=~data.
- 5 CNT_UP, 6 CNT_DN: counting, see REQ-017.
- 7: reserved, treated as NOP.
REQ-014 SHALL implement FSM states IDLE, APPLY, COUNT, DONE; cmd_ready=1 only in IDLE.
REQ-015 SHALL accept a command on a rising edge where cmd_valid & cmd_ready; cmd_op, cmd_data and cmd_steps SHALL be captured into internal registers on that edge.
REQ-016 For opcodes 0-4 and 7 the FSM SHALL go IDLE -> APPLY -> DONE -> IDLE.
- J/K are driven from the captured command only during APPLY; J=K=0 in every other state.
- q SHALL show the new value from the edge that ends APPLY.
- done=1 during DONE.
- Accept-to-done latency is exactly 2 cycles.
REQ-017 For CNT_UP and CNT_DN with steps>0 the FSM SHALL go IDLE -> COUNT -> DONE -> IDLE, staying in COUNT exactly steps cycles.
- Each COUNT cycle drives J=K=toggle mask.
- CNT_UP: bit i toggles iff q[i-1:0] are all 1.
- CNT_DN: bit i toggles iff q[i-1:0] are all 0.
- Bit 0 always toggles in both directions.
REQ-018 Counting SHALL wrap modulo 2^WIDTH (0xFF+1=0x00, 0x00-1=0xFF for WIDTH=8), with no error indication.
REQ-019 CNT_UP or CNT_DN with steps=0 SHALL go IDLE -> APPLY (J=K=0) -> DONE, leaving q unchanged.
REQ-020 Commands presented while busy=1 SHALL be neither accepted nor lost; cmd_valid is expected to stay high until accepted.
REQ-021 done SHALL never be high in the same cycle as cmd_ready.
- The earliest next acceptance is the cycle after DONE.
- Sustained throughput: one mask command per 3 cycles.
REQ-022 Each cell SHALL follow JK semantics on every clk edge:
- 00 hold
- 01 reset
- 10 set
- 11 toggle

Reset
REQ-023 rst=1 SHALL immediately, without waiting for clk, force the following, from any state including mid-COUNT:
- q=0
- state=IDLE
- done=0
- busy=0
- cmd_ready=1
- captured command registers cleared
REQ-024 A command interrupted by reset SHALL be discarded, and its done pulse SHALL never appear.
REQ-025 Command acceptance SHALL resume on the first rising edge after rst deasserts.

Structure
REQ-026 Package jk_seq_pkg SHALL hold the opcode enum, the FSM state enum and the default WIDTH/STEP_W constants.
REQ-027 SHALL instantiate WIDTH copies of sub-module jk_cell.
- Ports: clk, rst, j, k, q.
- Asynchronous reset to 0.
- Holds all per-bit storage; the sequencer contains only the control logic and the step counter.
REQ-028 The step counter SHALL be STEP_W bits, loaded from cmd_steps on acceptance and decremented in COUNT.

Verification
REQ-029 Reset, then LOAD 0xA5 -> q=0xA5 two cycles after acceptance, with done high for exactly one cycle.
REQ-030 From 0xA5, apply in sequence:
- TOG 0x0F -> 0xAA
- SET 0x50 -> 0xFA
- CLR 0x0A -> 0xF0
- op 7 -> 0xF0 unchanged, with done pulsed
REQ-031 LOAD 0xFE, then CNT_UP steps=3 -> q goes 0xFF, 0x00, 0x01 on consecutive cycles, busy stays high 4 cycles, and done follows.
REQ-032 LOAD 0x01, then CNT_DN steps=2 -> 0x00, 0xFF; separately, CNT_DN steps=0 -> q unchanged with done 2 cycles after acceptance.
REQ-033 cmd_valid held high with a second command during COUNT -> the second command is accepted only in the cycle after DONE, and the first command's result is intact.
REQ-034 rst pulsed asynchronously mid-COUNT (steps=10, after 4 cycles) -> q=0, cmd_ready=1 before the next edge, no done; a new LOAD 0x3C then completes normally.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK bank sequencer: opcode and FSM state enums
// plus the default bank geometry.
// Imported by jk_bank_sequencer; jk_cell needs none of it.
package jk_seq_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STEP_W = 8;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_SET    = 3'd1,
        OP_CLR    = 3'd2,
        OP_TOG    = 3'd3,
        OP_LOAD   = 3'd4,
        OP_CNT_UP = 3'd5,
        OP_CNT_DN = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Counting opcodes take the COUNT path when they carry a non-zero step count.
    function automatic logic is_count_op(input logic [2:0] op);
        return (op == OP_CNT_UP) || (op == OP_CNT_DN);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell: 00 hold, 01 reset, 10 set, 11 toggle on each clk edge.
// Latency: q reflects j/k one clk edge later. No flow control.
// Ports: clk, rst (async, active-high, clears q), j, k, q.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Sequences mask / load / count commands onto a bank of WIDTH JK cells.
// Latency: mask ops 2 cycles accept-to-done; counting steps+1 cycles. Backpressure:
// cmd_ready only in IDLE, so a held cmd_valid waits until the cycle after DONE.
// Ports: clk, rst (async active-high), cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_steps
// command handshake, q bank state, busy (not IDLE), done (one-cycle completion pulse).
module jk_bank_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              done
);

    state_e             state_q, state_d;
    op_e                op_q;
    logic [WIDTH-1:0]   data_q;
    logic [STEP_W-1:0]  steps_q, steps_d;

    logic               accept;
    logic [WIDTH-1:0]   j, k;
    logic [WIDTH-1:0]   tog_mask;
    logic               carry;

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

    // ------------------------------------------------------------------
    // State and captured-command registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            if (accept) begin
                op_q   <= op_e'(cmd_op);
                data_q <= cmd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and step counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    steps_d = cmd_steps;
                    // A zero-step count degenerates into a J=K=0 apply cycle
                    // so its latency matches the mask ops.
                    if (is_count_op(cmd_op) && (cmd_steps != '0)) begin
                        state_d = ST_COUNT;
                    end else begin
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_APPLY: begin
                state_d = ST_DONE;
            end
            ST_COUNT: begin
                steps_d = steps_q - STEP_W'(1);
                // steps_q holds the COUNT cycles remaining including this one.
                if (steps_q <= STEP_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Ripple toggle mask: bit i toggles when all lower bits are 1 (up)
    // or all lower bits are 0 (down); bit 0 always toggles.
    // ------------------------------------------------------------------
    always_comb begin
        tog_mask = '0;
        carry    = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tog_mask[i] = carry;
            if (op_q == OP_CNT_DN) begin
                carry = carry & ~q[i];
            end else begin
                carry = carry & q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // J/K drive: only APPLY and COUNT ever disturb the bank.
    // ------------------------------------------------------------------
    always_comb begin
        j = '0;
        k = '0;
        if (state_q == ST_APPLY) begin
            unique case (op_q)
                OP_SET: begin
                    j = data_q;
                end
                OP_CLR: begin
                    k = data_q;
                end
                OP_TOG: begin
                    j = data_q;
                    k = data_q;
                end
                OP_LOAD: begin
                    j = data_q;
                    k = ~data_q;
                end
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end else if (state_q == ST_COUNT) begin
            j = tog_mask;
            k = tog_mask;
        end
    end

    // ------------------------------------------------------------------
    // Bank storage
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j[gi]),
            .k   (k[gi]),
            .q   (q[gi])
        );
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
module tb_jk_bank_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] cmd_steps;
    logic [7:0] q;
    logic       busy;
    logic       done;

    int total;
    int bad;

    jk_bank_sequencer #(.WIDTH(8), .STEP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command, wait (bounded) for acceptance, return #1 after the
    // accepting edge with cmd_valid dropped.
    task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [7:0] s);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_steps = s;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout ready=%b required=1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        total++;
        if ({q, cmd_ready, busy, done} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state q=%h rdy=%b busy=%b done=%b required q=00 rdy=1 busy=0 done=0",
                     q, cmd_ready, busy, done);
        end
    endtask

    task automatic test_load();
        send(3'd4, 8'hA5, 8'd0);
        total++;
        if ({busy, done, cmd_ready} !== 3'b100) begin
            bad++;
            $display("FAIL load_apply busy=%b done=%b rdy=%b required 1 0 0", busy, done, cmd_ready);
        end
        tick(1);
        total++;
        if (q !== 8'hA5 || done !== 1'b1) begin
            bad++;
            $display("FAIL load_result q=%h done=%b required A5 1", q, done);
        end
        tick(1);
        total++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || q !== 8'hA5) begin
            bad++;
            $display("FAIL load_after done=%b rdy=%b q=%h required 0 1 A5", done, cmd_ready, q);
        end
    endtask

    task automatic test_masks();
        logic [2:0] ops [4];
        logic [7:0] dat [4];
        logic [7:0] exp [4];
        ops[0] = 3'd3; dat[0] = 8'h0F; exp[0] = 8'hAA;
        ops[1] = 3'd1; dat[1] = 8'h50; exp[1] = 8'hFA;
        ops[2] = 3'd2; dat[2] = 8'h0A; exp[2] = 8'hF0;
        ops[3] = 3'd7; dat[3] = 8'hFF; exp[3] = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            send(ops[i], dat[i], 8'd0);
            tick(1);
            total++;
            if (q !== exp[i] || done !== 1'b1 || cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL mask_op%0d q=%h done=%b rdy=%b required %h 1 0",
                         i, q, done, cmd_ready, exp[i]);
            end
            tick(1);
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL mask_pulse%0d done=%b required 0", i, done);
            end
        end
    endtask

    task automatic test_count_up();
        logic [7:0] exp [3];
        int busy_cycles;
        exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'h01;
        send(3'd4, 8'hFE, 8'd0);
        tick(2);
        send(3'd5, 8'h00, 8'd3);
        busy_cycles = 1;
        total++;
        if (q !== 8'hFE || busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL up_first q=%h busy=%b done=%b required FE 1 0", q, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (busy === 1'b1) busy_cycles++;
            total++;
            if (q !== exp[i] || done !== (i == 2)) begin
                bad++;
                $display("FAIL up_step%0d q=%h done=%b required %h %b", i, q, done, exp[i], (i == 2));
            end
        end
        tick(1);
        total++;
        if (busy !== 1'b0 || busy_cycles != 4) begin
            bad++;
            $display("FAIL up_busy cycles=%0d busy=%b required 4 0", busy_cycles, busy);
        end
    endtask

    task automatic test_count_dn();
        send(3'd4, 8'h01, 8'd0);
        tick(2);
        send(3'd6, 8'h00, 8'd2);
        tick(1);
        total++;
        if (q !== 8'h00 || done !== 1'b0) begin
            bad++;
            $display("FAIL dn_step0 q=%h done=%b required 00 0", q, done);
        end
        tick(1);
        total++;
        if (q !== 8'hFF || done !== 1'b1) begin
            bad++;
            $display("FAIL dn_step1 q=%h done=%b required FF 1", q, done);
        end
        tick(1);
        send(3'd6, 8'h00, 8'd0);
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || q !== 8'hFF) begin
            bad++;
            $display("FAIL dn_zero_apply busy=%b done=%b q=%h required 1 0 FF", busy, done, q);
        end
        tick(1);
        total++;
        if (done !== 1'b1 || q !== 8'hFF) begin
            bad++;
            $display("FAIL dn_zero_done done=%b q=%h required 1 FF", done, q);
        end
        tick(1);
    endtask

    task automatic test_back_to_back();
        send(3'd4, 8'h00, 8'd0);
        tick(2);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_data  = 8'h00;
        cmd_steps = 8'd4;
        @(posedge clk);
        #1;
        // Second command queued behind the count, valid held high.
        cmd_op   = 3'd4;
        cmd_data = 8'h77;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_blocked%0d rdy=%b busy=%b required 0 1", i, cmd_ready, busy);
            end
            tick(1);
        end
        total++;
        if (q !== 8'h04 || done !== 1'b1 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first q=%h done=%b rdy=%b required 04 1 0", q, done, cmd_ready);
        end
        tick(1);
        total++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || q !== 8'h04) begin
            bad++;
            $display("FAIL b2b_idle rdy=%b done=%b q=%h required 1 0 04", cmd_ready, done, q);
        end
        tick(1);
        cmd_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || q !== 8'h04) begin
            bad++;
            $display("FAIL b2b_accept busy=%b q=%h required 1 04", busy, q);
        end
        tick(1);
        total++;
        if (q !== 8'h77 || done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second q=%h done=%b required 77 1", q, done);
        end
        tick(1);
    endtask

    task automatic test_reset_mid_count();
        int done_seen;
        send(3'd5, 8'h00, 8'd10);
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({q, cmd_ready, busy, done} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset q=%h rdy=%b busy=%b done=%b required 00 1 0 0",
                     q, cmd_ready, busy, done);
        end
        #1;
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (done === 1'b1 || q !== 8'h00) done_seen++;
        end
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("FAIL reset_discard stray_cycles=%0d required 0", done_seen);
        end
        send(3'd4, 8'h3C, 8'd0);
        tick(1);
        total++;
        if (q !== 8'h3C || done !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_load q=%h done=%b required 3C 1", q, done);
        end
        tick(1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'h00;
        cmd_steps = 8'd0;
        #12;
        test_reset();
        #5;
        rst = 1'b0;
        test_load();
        test_masks();
        test_count_up();
        test_count_dn();
        test_back_to_back();
        test_reset_mid_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
